program_loader: RTL and testbench

//  Writer side of the pipeline's instruction/data memories: accepts a byte stream, assembles
//  16-bit big-endian words, writes them sequentially into a memory write port (ROM/RAM init

---
 rtl/program_loader.sv | 154 +++++++++++++++
 tb/tb_program_loader.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// program_loader: turns a framed byte stream into 16-bit big-endian memory
// writes and holds the CPU until a complete image with a good checksum is loaded.
// Frame layout: LEN_HI, LEN_LO, 2*N data bytes (hi byte then lo byte for each
// word), then one CHK byte equal to the 8-bit sum of the data bytes.
module program_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  // Lengths are compared in 17 bits so that a full 16-bit length can never wrap.
  localparam logic [16:0]       DEPTH_L = 17'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(BASE);

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] len;
  logic [7:0]  data_hi;
  logic [7:0]  checksum;
  logic        accept;

  // A byte moves only when the loader is ready and the source offers one.
  assign accept = in_valid && in_ready;

  // Loader FSM. All outputs are registered. in_ready is set on every transition
  // into a byte-accepting state and cleared on every transition out of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      len_hi       <= 8'h00;
      len          <= 16'h0000;
      data_hi      <= 8'h00;
      checksum     <= 8'h00;
      in_ready     <= 1'b0;
      mem_addr     <= '0;
      mem_data     <= 16'h0000;
      mem_wren     <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'h0000;
    end else begin
      // The write strobe lasts exactly one cycle; only DATA_LO raises it again.
      mem_wren <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN_HI;
            in_ready     <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_hold     <= 1'b1;
            words_loaded <= 16'h0000;
            checksum     <= 8'h00;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= in_byte;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len <= {len_hi, in_byte};
            if ({len_hi, in_byte} == 16'h0000) begin
              // An empty image goes straight to the checksum byte (expected 0).
              state <= S_CHK;
            end else if ({1'b0, len_hi, in_byte} > DEPTH_L) begin
              // Oversized image is rejected before any memory is touched.
              state    <= S_ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
            end else begin
              state <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            data_hi  <= in_byte;
            checksum <= checksum + in_byte;
            state    <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            // Address and data are presented together with the strobe in WRITE.
            checksum <= checksum + in_byte;
            mem_wren <= 1'b1;
            mem_addr <= BASE_A + ADDR_W'(words_loaded);
            mem_data <= {data_hi, in_byte};
            in_ready <= 1'b0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          in_ready     <= 1'b1;
          if (({1'b0, words_loaded} + 17'd1) < {1'b0, len}) begin
            state <= S_DATA_HI;
          end else begin
            state <= S_CHK;
          end
        end
        S_CHK: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_byte == checksum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= S_ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: drives framed byte streams, logs every
// memory write seen on the write port and checks status/write results against
// hand-computed values.
module tb_program_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_wren;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] wr_addr[$];
  logic [15:0] wr_data[$];

  program_loader #(.ADDR_W(16), .DEPTH(256), .BASE(0)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .in_byte(in_byte),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .mem_wren(mem_wren),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-port monitor, sampled mid-cycle; WRITE lasts one cycle so each write is seen once.
  always @(negedge clk) begin
    if (reset === 1'b1 && mem_wren === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
      $display("write addr=%04h data=%04h", mem_addr, mem_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one byte; returns at the falling edge after it was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    in_byte  = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      check("byte_accept_timeout", 32'(in_ready), 32'd1);
    end else begin
      @(negedge clk);
    end
    $display("byte %02h sent", b);
    in_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_two_word_frame(input logic [7:0] chk, input bit gap);
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_byte(8'h12, gap);
    send_byte(8'h34, gap);
    send_byte(8'hAB, gap);
    send_byte(8'hCD, gap);
    send_byte(chk, gap);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0000);
      check({tag, "_data0"}, 32'(wr_data[0]), 32'h1234);
      check({tag, "_addr1"}, 32'(wr_addr[1]), 32'h0001);
      check({tag, "_data1"}, 32'(wr_data[1]), 32'hABCD);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_byte  = 8'h00;
    in_valid = 1'b0;

    // Reset values, both while held and after release.
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_cpu_hold", 32'(cpu_hold), 32'd1);
    check("idle_done", 32'(done), 32'd0);
    check("idle_error", 32'(error), 32'd0);
    check("idle_mem_wren", 32'(mem_wren), 32'd0);
    check("idle_words", 32'(words_loaded), 32'd0);

    // Good two-word frame, continuous stream: sum 12+34+AB+CD = 0x1BE -> CHK BE.
    clear_log();
    pulse_start();
    check("good_in_ready_after_start", 32'(in_ready), 32'd1);
    send_two_word_frame(8'hBE, 1'b0);
    check_two_writes("good");
    check("good_done", 32'(done), 32'd1);
    check("good_error", 32'(error), 32'd0);
    check("good_cpu_hold", 32'(cpu_hold), 32'd0);
    check("good_words", 32'(words_loaded), 32'd2);
    check("good_in_ready", 32'(in_ready), 32'd0);
    check("good_addr_hold", 32'(mem_addr), 32'h0001);
    check("good_data_hold", 32'(mem_data), 32'hABCD);

    // Same frame with a wrong checksum: writes still happen, image rejected.
    clear_log();
    pulse_start();
    check("bad_done_cleared", 32'(done), 32'd0);
    check("bad_words_cleared", 32'(words_loaded), 32'd0);
    check("bad_cpu_hold_raised", 32'(cpu_hold), 32'd1);
    send_two_word_frame(8'h15, 1'b0);
    check_two_writes("bad");
    check("bad_error", 32'(error), 32'd1);
    check("bad_done", 32'(done), 32'd0);
    check("bad_cpu_hold", 32'(cpu_hold), 32'd1);

    // Oversized length 257: error right after LEN_LO, nothing written.
    clear_log();
    pulse_start();
    check("big_error_cleared", 32'(error), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("big_error", 32'(error), 32'd1);
    check("big_done", 32'(done), 32'd0);
    check("big_in_ready", 32'(in_ready), 32'd0);
    check("big_nwrites", 32'(wr_addr.size()), 32'd0);

    // Length 256 is legal: loader moves on to data bytes without error.
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    check("max_error", 32'(error), 32'd0);
    check("max_in_ready", 32'(in_ready), 32'd1);
    // Abandon it with a reset.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Empty image; a start issued mid-header must be ignored.
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("empty_done", 32'(done), 32'd1);
    check("empty_error", 32'(error), 32'd0);
    check("empty_words", 32'(words_loaded), 32'd0);
    check("empty_nwrites", 32'(wr_addr.size()), 32'd0);

    // in_valid toggling every cycle: same writes, just slower.
    clear_log();
    pulse_start();
    send_two_word_frame(8'hBE, 1'b1);
    check_two_writes("gap");
    check("gap_done", 32'(done), 32'd1);
    check("gap_words", 32'(words_loaded), 32'd2);

    // Reset after the first WRITE of a two-word frame.
    clear_log();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    @(negedge clk);
    check("mid_nwrites", 32'(wr_addr.size()), 32'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_words", 32'(words_loaded), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_data", 32'(mem_data), 32'd0);
    check("mid_rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    clear_log();
    pulse_start();
    send_two_word_frame(8'hBE, 1'b0);
    check_two_writes("post");
    check("post_done", 32'(done), 32'd1);
    check("post_cpu_hold", 32'(cpu_hold), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
